serial_to_parallel: RTL and testbench

- Receive-side counterpart of the localizer serialiser.
- Collects a stream of single (data, 4-bit index) beats back into a BUS_WIDTH-wide parallel frame of data words and indices.
- Presents the frame to downstream logic with a valid/ready handshake.
- Sits where a serial result stream re-enters a wide datapath, e.g. feeding sorted distances back to the meteor-selection logic.

---
 rtl/serial_to_parallel.sv | 112 +++++++++++
 tb/tb_serial_to_parallel.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/serial_to_parallel.sv
// Serial-to-parallel frame collector: packs (data, index) beats into a BUS_WIDTH-slot frame.
// Optional macro S2P_GAP_FLUSH_EN: an in_valid gap closes a non-empty partial frame early.
module serial_to_parallel #(
    parameter int unsigned DW        = 32,
    parameter int unsigned BUS_WIDTH = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [DW-1:0]        din,
    input  logic [3:0]           input_index,
    output logic                 in_ready,
    output logic [DW-1:0]        dout [BUS_WIDTH-1:0],
    output logic [3:0]           output_indices [BUS_WIDTH-1:0],
    output logic [BUS_WIDTH-1:0] slot_valid,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 drop_err
);

    localparam int unsigned CW = (BUS_WIDTH > 1) ? $clog2(BUS_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_SLOT = CW'(BUS_WIDTH - 1);

    typedef enum logic {
        COLLECT,
        HOLD
    } state_e;

    state_e                 state_q;
    logic [CW-1:0]          count_q;
    logic [CW-1:0]          count_d;
    logic [DW-1:0]          data_q [BUS_WIDTH-1:0];
    logic [3:0]             idx_q  [BUS_WIDTH-1:0];
    logic [BUS_WIDTH-1:0]   slot_valid_q;
    logic                   in_ready_q;
    logic                   out_valid_q;
    logic                   drop_q;

    assign count_d = count_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= COLLECT;
            count_q      <= '0;
            slot_valid_q <= '0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            drop_q       <= 1'b0;
            for (int unsigned k = 0; k < BUS_WIDTH; k++) begin
                data_q[k] <= '1;
                idx_q[k]  <= '1;
            end
        end else begin
            // in_ready_q is low exactly in HOLD, so any beat offered there is lost
            if (in_valid && !in_ready_q) begin
                drop_q <= 1'b1;
            end
            case (state_q)
                COLLECT: begin
                    if (in_valid) begin
                        data_q[count_q]       <= din;
                        idx_q[count_q]        <= input_index;
                        slot_valid_q[count_q] <= 1'b1;
                        if (count_q == LAST_SLOT) begin
                            count_q     <= '0;
                            state_q     <= HOLD;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end else begin
                            count_q <= count_d;
                        end
                    end
`ifdef S2P_GAP_FLUSH_EN
                    else if (count_q != '0) begin
                        count_q     <= '0;
                        state_q     <= HOLD;
                        in_ready_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                    end
`endif
                end
                HOLD: begin
                    if (out_ready) begin
                        state_q      <= COLLECT;
                        count_q      <= '0;
                        slot_valid_q <= '0;
                        in_ready_q   <= 1'b1;
                        out_valid_q  <= 1'b0;
                        for (int unsigned k = 0; k < BUS_WIDTH; k++) begin
                            data_q[k] <= '1;
                            idx_q[k]  <= '1;
                        end
                    end
                end
                default: state_q <= COLLECT;
            endcase
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < BUS_WIDTH; k++) begin
            dout[k]           = data_q[k];
            output_indices[k] = idx_q[k];
        end
    end

    assign slot_valid = slot_valid_q;
    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign drop_err   = drop_q;

endmodule

// File: tb/tb_serial_to_parallel.sv
// Scoreboard bench for serial_to_parallel: queue-based frame model feeds expected frames to a monitor.
module tb_serial_to_parallel;

    localparam int unsigned DW = 32;
    localparam int unsigned BW = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [DW-1:0] din = '0;
    logic [3:0]    input_index = '0;
    logic          in_ready;
    logic [DW-1:0] dout [BW-1:0];
    logic [3:0]    output_indices [BW-1:0];
    logic [BW-1:0] slot_valid;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          drop_err;

    serial_to_parallel #(.DW(DW), .BUS_WIDTH(BW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .din(din), .input_index(input_index),
        .in_ready(in_ready), .dout(dout), .output_indices(output_indices),
        .slot_valid(slot_valid), .out_valid(out_valid), .out_ready(out_ready), .drop_err(drop_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [BW-1:0][DW-1:0] d;
        logic [BW-1:0][3:0]    ix;
        logic [BW-1:0]         m;
    } frame_t;

    frame_t        expq [$];
    logic [DW-1:0] part_d [$];
    logic [3:0]    part_ix [$];
    bit            hold_m = 1'b0;
    bit            drop_m = 1'b0;
    bit            mon_en = 1'b0;
    int unsigned   n_chk = 0;
    int unsigned   n_pass = 0;

    function automatic void chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endfunction

    // Turn the collected beats into the frame the DUT should present.
    function automatic void close_frame();
        frame_t f;
        f.d  = '1;
        f.ix = '1;
        f.m  = '0;
        for (int k = 0; k < part_d.size(); k++) begin
            f.d[k]  = part_d[k];
            f.ix[k] = part_ix[k];
            f.m[k]  = 1'b1;
        end
        expq.push_back(f);
        part_d.delete();
        part_ix.delete();
        hold_m = 1'b1;
    endfunction

    // Reference model advanced once per rising edge with the inputs the DUT sampled.
    function automatic void model_step();
        if (rst) begin
            part_d.delete();
            part_ix.delete();
            expq.delete();
            hold_m = 1'b0;
            drop_m = 1'b0;
        end else if (hold_m) begin
            if (in_valid) drop_m = 1'b1;
            if (out_ready) hold_m = 1'b0;
        end else if (in_valid) begin
            part_d.push_back(din);
            part_ix.push_back(input_index);
            if (part_d.size() == BW) close_frame();
        end
`ifdef S2P_GAP_FLUSH_EN
        else if (part_d.size() > 0) begin
            close_frame();
        end
`endif
    endfunction

    task automatic step(input bit v, input logic [DW-1:0] d, input logic [3:0] ix,
                        input bit ordy, input bit r);
        in_valid    = v;
        din         = d;
        input_index = ix;
        out_ready   = ordy;
        rst         = r;
        @(posedge clk);
        model_step();
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("in_ready", DW'(in_ready), DW'(!hold_m));
            chk("out_valid", DW'(out_valid), DW'(hold_m));
            chk("drop_err", DW'(drop_err), DW'(drop_m));
            if (out_valid === 1'b1) begin
                if (expq.size() == 0) begin
                    chk("frame_expected", 32'd0, 32'd1);
                end else begin
                    chk("slot_valid", DW'(slot_valid), DW'(expq[0].m));
                    for (int k = 0; k < BW; k++) begin
                        chk($sformatf("dout[%0d]", k), dout[k], expq[0].d[k]);
                        chk($sformatf("idx[%0d]", k), DW'(output_indices[k]), DW'(expq[0].ix[k]));
                    end
                    if (out_ready) void'(expq.pop_front());
                end
            end
        end
    end

    initial begin
        step(0, '0, '0, 0, 1);
        mon_en = 1'b1;
        step(0, '0, '0, 1, 0);

        // full frame
        for (int k = 0; k < BW; k++) step(1, DW'(100 + k), 4'(k), 1, 0);
        for (int k = 0; k < 3; k++) step(0, '0, '0, 1, 0);

        // backpressure with a dropped beat in the third stalled cycle
        for (int k = 0; k < BW; k++) step(1, $urandom, 4'($urandom), 0, 0);
        for (int k = 0; k < 5; k++) step(k == 2, 32'hDEAD_BEEF, 4'h3, 0, 0);
        step(0, '0, '0, 1, 0);
        step(0, '0, '0, 1, 0);

        // reset mid-frame
        for (int k = 0; k < 7; k++) step(1, $urandom, 4'($urandom), 1, 0);
        step(0, '0, '0, 1, 1);
        step(0, '0, '0, 1, 0);
        for (int k = 0; k < BW; k++) step(1, DW'(k), 4'(k), 1, 0);
        step(0, '0, '0, 1, 0);

        // back-to-back stream; beat 12 lands in the bubble
        for (int k = 0; k < 2 * BW; k++) step(1, DW'(1000 + k), 4'(k), 1, 0);
        for (int k = 0; k < 3; k++) step(0, '0, '0, 1, 0);
        step(1, 32'hCAFE_0001, 4'hF, 1, 0);
        step(0, '0, '0, 1, 1);

        // gap mid-frame
        for (int k = 0; k < 5; k++) step(1, DW'(500 + k), 4'(k), 1, 0);
        for (int k = 0; k < 10; k++) step(0, '0, '0, 1, 0);
        for (int k = 0; k < 7; k++) step(1, DW'(600 + k), 4'(k + 5), 1, 0);
        for (int k = 0; k < 3; k++) step(0, '0, '0, 1, 0);

        // randomized traffic with occasional resets
        for (int c = 0; c < 600; c++)
            step($urandom_range(9, 0) < 7, $urandom, 4'($urandom),
                 $urandom_range(1, 0) == 1, $urandom_range(99, 0) == 0);

        for (int k = 0; k < 5; k++) step(0, '0, '0, 1, 0);
        chk("expq_empty", DW'(expq.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
